// File: rtl/man_encoding_slave.sv
// Slave-side Manchester transmitter: sends a 7-bit response frame (S, D0..D3, P, E)
// after a programmable pause, gating the line driver through tx_en.
module man_encoding_slave #(
   parameter int unsigned HALF_BIT   = 36,
   parameter int unsigned RESP_DELAY = 144,
   parameter bit          IDLE_LEVEL = 1'b1
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] data,
   output logic       manchester_out,
   output logic       tx_en,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CntMax = (RESP_DELAY > HALF_BIT) ? RESP_DELAY : HALF_BIT;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StDelay = 2'd1;
   localparam logic [1:0] StSend  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      hidx_q, hidx_d;
   logic [13:0]     halves_q, halves_d;
   logic            out_q, out_d;
   logic            tx_en_q, tx_en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [6:0]      frame;
   logic [13:0]     pattern;

   // Half-bit sequence in line order: bit i becomes {~b, b} at halves 2i, 2i+1.
   always_comb begin
      frame   = {1'b1, ^data, data, 1'b0};
      pattern = '0;
      for (int i = 0; i < 7; i++) begin
         pattern[2*i]   = ~frame[i];
         pattern[2*i+1] = frame[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hidx_d   = hidx_q;
      halves_d = halves_q;
      out_d    = out_q;
      tx_en_d  = tx_en_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               halves_d = pattern;
               busy_d   = 1'b1;
               cnt_d    = '0;
               state_d  = (RESP_DELAY == 0) ? StSend : StDelay;
            end
         end
         StDelay: begin
            if (cnt_q == CntW'(RESP_DELAY - 1)) begin
               cnt_d   = '0;
               state_d = StSend;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSend: begin
            // First SEND cycle only puts half 0 on the line.
            if (!tx_en_q) begin
               tx_en_d = 1'b1;
               out_d   = halves_q[0];
               cnt_d   = '0;
               hidx_d  = '0;
            end else if (cnt_q == CntW'(HALF_BIT - 1)) begin
               cnt_d = '0;
               if (hidx_q == 4'd13) begin
                  state_d = StDone;
                  tx_en_d = 1'b0;
                  out_d   = IDLE_LEVEL;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  hidx_d  = '0;
               end else begin
                  hidx_d   = hidx_q + 4'd1;
                  halves_d = {1'b0, halves_q[13:1]};
                  out_d    = halves_q[1];
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         hidx_q   <= '0;
         halves_q <= '0;
         out_q    <= IDLE_LEVEL;
         tx_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hidx_q   <= hidx_d;
         halves_q <= halves_d;
         out_q    <= out_d;
         tx_en_q  <= tx_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign manchester_out = out_q;
   assign tx_en          = tx_en_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_man_encoding_slave.sv
// Randomized bench for man_encoding_slave: a default build and a fast build
// (HALF_BIT=4, RESP_DELAY=0) share stimulus and are checked cycle by cycle.
module tb_man_encoding_slave;

   localparam int HbA = 36;
   localparam int RdA = 144;
   localparam int HbB = 4;
   localparam int RdB = 0;

   logic       clk_in = 1'b0;
   logic       rst    = 1'b1;
   logic       start  = 1'b0;
   logic [3:0] data   = 4'd0;

   logic out_a, tx_en_a, busy_a, done_a;
   logic out_b, tx_en_b, busy_b, done_b;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference state per build: frame in flight, its acceptance edge and nibble.
   bit         act [2];
   int         t0  [2];
   logic [3:0] dat [2];

   always #5 clk_in = ~clk_in;

   man_encoding_slave dut_a (
      .clk_in         (clk_in),
      .rst            (rst),
      .start          (start),
      .data           (data),
      .manchester_out (out_a),
      .tx_en          (tx_en_a),
      .busy           (busy_a),
      .done           (done_a)
   );

   man_encoding_slave #(
      .HALF_BIT   (HbB),
      .RESP_DELAY (RdB),
      .IDLE_LEVEL (1'b1)
   ) dut_b (
      .clk_in         (clk_in),
      .rst            (rst),
      .start          (start),
      .data           (data),
      .manchester_out (out_b),
      .tx_en          (tx_en_b),
      .busy           (busy_b),
      .done           (done_b)
   );

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got {line,tx_en,busy,done}=%b, expected %b",
                  tag, cyc, got, exp);
      end
   endtask

   // Frame bit k of the response: S, D0..D3, even parity, E.
   function automatic logic frame_bit(input logic [3:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 4) return d[k-1];
      if (k == 5) return ^d;
      return 1'b1;
   endfunction

   // Expected outputs after edge n, as {line, tx_en, busy, done}.
   function automatic logic [3:0] expect_out(input int n, input bit a, input int ts,
                                             input logic [3:0] d, input int hb, input int rd);
      int   rel;
      int   half;
      logic b;
      logic line;
      logic en;
      logic bsy;
      logic dn;
      if (!a) return 4'b1000;
      rel  = n - ts - 1 - rd;
      line = 1'b1;
      en   = 1'b0;
      bsy  = (rel < 14 * hb);
      dn   = (rel == 14 * hb);
      if (rel >= 0 && rel < 14 * hb) begin
         half = rel / hb;
         b    = frame_bit(d, half / 2);
         line = (half % 2 == 1) ? b : ~b;
         en   = 1'b1;
      end
      return {line, en, bsy, dn};
   endfunction

   task automatic model_edge(input int i, input int hb, input int rd);
      if (rst) begin
         act[i] = 1'b0;
      end else if (start && (!act[i] || cyc >= t0[i] + rd + 14 * hb + 3)) begin
         act[i] = 1'b1;
         t0[i]  = cyc;
         dat[i] = data;
      end
   endtask

   task automatic step(input logic s, input logic [3:0] d, input logic r);
      start = s;
      data  = d;
      rst   = r;
      @(posedge clk_in);
      cyc++;
      model_edge(0, HbA, RdA);
      model_edge(1, HbB, RdB);
      #1;
      check_eq("default_build", {out_a, tx_en_a, busy_a, done_a},
               expect_out(cyc, act[0], t0[0], dat[0], HbA, RdA));
      check_eq("fast_build", {out_b, tx_en_b, busy_b, done_b},
               expect_out(cyc, act[1], t0[1], dat[1], HbB, RdB));
   endtask

   logic [3:0] nibbles [3];

   initial begin
      nibbles[0] = 4'b1010;
      nibbles[1] = 4'b1111;
      nibbles[2] = 4'b0111;
      act[0] = 1'b0;
      act[1] = 1'b0;
      t0[0]  = 0;
      t0[1]  = 0;

      for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1);
      for (int i = 0; i < 1000; i++) step(1'b0, 4'($urandom), 1'b0);

      // Directed nibbles; extra starts at cycle 200 and in the done cycle.
      for (int f = 0; f < 3; f++) begin
         step(1'b1, nibbles[f], 1'b0);
         for (int j = 1; j <= 700; j++)
            step((j == 200) || (j == RdA + 14 * HbA + 2), 4'($urandom), 1'b0);
      end

      // Start held high: each done cycle must ignore it.
      for (int i = 0; i < 1400; i++) step(1'b1, 4'($urandom), 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 4'($urandom), 1'b0);

      // Reset during half 6, coincident with start, then a fresh frame.
      step(1'b1, 4'($urandom), 1'b0);
      for (int j = 1; j <= 1 + RdA + 6 * HbA + 10; j++) step(1'b0, 4'($urandom), 1'b0);
      step(1'b1, 4'($urandom), 1'b1);
      step(1'b0, 4'($urandom), 1'b0);
      step(1'b1, 4'($urandom), 1'b0);
      for (int j = 0; j < 700; j++) step(1'b0, 4'($urandom), 1'b0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) == 0, 4'($urandom), $urandom_range(0, 1499) == 0);
      for (int i = 0; i < 700; i++) step(1'b0, 4'($urandom), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/man_encoding_slave.md
Name: man_encoding_slave

Overview:
Slave-side Manchester transmitter for the ASI link. It is the response path paired with the slave Manchester decoder. It takes a 4-bit slave response nibble and builds a 7-bit frame: start, D0..D3, parity, end. After a programmable slave pause it drives the frame onto the line at one bit per 6 us (12 MHz clk_in). It sits between the slave application/SPI logic and the line driver, and gates the driver through tx_en.

Parameters:
HALF_BIT, 36, clk_in cycles per Manchester half-bit (36 = 3 us at 12 MHz; bit = 72 cycles)
RESP_DELAY, 144, clk_in cycles of slave pause between accepted start and first half-bit; 0 is legal
IDLE_LEVEL, 1, line level driven while not transmitting

Ports:
clk_in  input  1  system clock, 12 MHz
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle request to transmit; sampled only in IDLE
data  input  4  response nibble, data[0] = D0; latched on accepted start
manchester_out  output  1  Manchester-encoded line
tx_en  output  1  line-driver enable; high only while frame bits are on the line
busy  output  1  high from cycle after accepted start until done cycle (exclusive)
done  output  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset: on any clk_in edge with rst=1, all outputs go to their reset values on that edge: state=IDLE, manchester_out=IDLE_LEVEL, tx_en=0, busy=0, done=0, all counters 0. This applies mid-frame too; the frame is aborted and no done pulse is issued.
- Frame: bits in transmit order are S=0, D0, D1, D2, D3, P=D0^D1^D2^D3 (even parity over data+P), E=1. The frame is fixed at 7 bits.
- Encoding: each bit lasts 2*HALF_BIT cycles. The first half drives ~bit and the second half drives bit. A '1' is therefore low→high at mid-bit, and a '0' is high→low.
- FSM states are IDLE, DELAY, SEND and DONE.
  - IDLE: busy=0. If start=1, latch frame from data, go to DELAY (or SEND if RESP_DELAY=0); busy=1 from the next cycle.
  - DELAY: count RESP_DELAY cycles; line stays IDLE_LEVEL, tx_en=0; then go to SEND.
  - SEND: tx_en=1. A half-bit counter runs 0..HALF_BIT-1 and a half index runs 0..13. manchester_out is registered and updates at each half boundary. After half 13 completes, go to DONE.
  - DONE: one cycle. done=1, busy=0, tx_en=0, manchester_out=IDLE_LEVEL. Then go to IDLE.
- Latency: start sampled high at edge k. The first half of S appears on manchester_out at edge k+1+RESP_DELAY. The frame occupies 14*HALF_BIT cycles (504 default). done is high for the single cycle after the last half-bit.
- start while busy=1, or in the DONE cycle, is ignored (no queueing). data changes after acceptance do not affect the frame in flight.
- rst and start in the same cycle: reset wins; start is dropped.
- Counter widths: sized to hold max(RESP_DELAY, HALF_BIT) - 1, with no wrap inside a phase. The half index is 4 bits, and the terminal value 13 is decoded explicitly.

Test Plan:
- Reset then idle 1000 cycles -> manchester_out=1, tx_en=0, busy=0, done=0 throughout.
- start with data=4'b1010, defaults -> after 145 cycles tx_en=1. Bits 0,0,1,0,1,0,1 appear as halves H L, H L, L H, H L, L H, H L, L H. Each half is exactly 36 cycles. done pulses once, 504 cycles after tx_en rises, then the line returns to 1.
- data=4'b1111 and data=4'b0111 -> parity bit 0 and 1 respectively. Check the half-pair for bit 5 (H L vs L H).
- Second start pulse at cycle 200 of a frame, and a start in the done cycle -> both ignored. Exactly one frame is sent, with the original data.
- rst=1 asserted at half 6 of a frame -> next edge: line=1, tx_en=0, busy=0, no done. A new start then produces a complete correct frame.
- RESP_DELAY=0, HALF_BIT=4 build -> first half of S appears one cycle after start; the frame lasts 56 cycles.
